// File: rtl/e_calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// e_calc_pkg : shared word type, word width and state encodings for e_calc
// Rev 1.0
// ---------------------------------------------------------------------------
package e_calc_pkg;

  localparam int c_word_w = 16;

  typedef logic [c_word_w-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SQUARE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_RUN  = 2'd1,
    SQ_FIN  = 2'd2
  } sq_state_t;

endpackage
`default_nettype wire

// File: rtl/e_calc_squarer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_squarer : word-serial multi-precision fixed-point squarer
// Rev 1.0
// ---------------------------------------------------------------------------
module mp_squarer
  import e_calc_pkg::*;
#(
  parameter int WORDS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [c_word_w*WORDS-1:0] x_i,
  output logic                      done_o,
  output logic [c_word_w*WORDS-1:0] y_o
);

  localparam int c_fw = c_word_w * WORDS;
  localparam int c_aw = 2 * c_fw;
  localparam int c_iw = $clog2(WORDS);
  localparam logic [c_iw-1:0] c_last = c_iw'(WORDS - 1);

  sq_state_t           state_q;
  word_t               a_q [WORDS];
  logic [c_aw-1:0]     acc_q;
  logic [c_iw-1:0]     i_q;
  logic [c_iw-1:0]     j_q;
  logic                done_q;
  logic [c_fw-1:0]     y_q;

  logic [2*c_word_w-1:0] w_pp;
  logic [c_iw:0]         w_pos;
  logic [c_aw-1:0]       w_pp_shift;

  // One 16x16 partial product per cycle, placed at word offset i+j
  assign w_pp       = {{c_word_w{1'b0}}, a_q[i_q]} * {{c_word_w{1'b0}}, a_q[j_q]};
  assign w_pos      = {1'b0, i_q} + {1'b0, j_q};
  assign w_pp_shift = {{(c_aw-2*c_word_w){1'b0}}, w_pp} << {w_pos, 4'b0000};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= SQ_IDLE;
      a_q     <= '{default: '0};
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SQ_IDLE: begin
          if (start_i) begin
            for (int k = 0; k < WORDS; k++) begin
              a_q[k] <= x_i[c_word_w*k +: c_word_w];
            end
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= SQ_RUN;
          end
        end
        SQ_RUN: begin
          acc_q <= acc_q + w_pp_shift;
          if (j_q == c_last) begin
            j_q <= '0;
            if (i_q == c_last) begin
              state_q <= SQ_FIN;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        SQ_FIN: begin
          // Keep the integer word and the top fraction words; drop the rest
          y_q     <= acc_q[c_word_w*(2*WORDS-1)-1 : c_word_w*(WORDS-1)];
          done_q  <= 1'b1;
          state_q <= SQ_IDLE;
        end
        default: state_q <= SQ_IDLE;
      endcase
    end
  end

  assign done_o = done_q;
  assign y_o    = y_q;

endmodule
`default_nettype wire

// File: rtl/e_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// e_calc : computes (1 + 1/N)^N by repeated multi-precision squaring
// Rev 1.0
// ---------------------------------------------------------------------------
module e_calc
  import e_calc_pkg::*;
#(
  parameter int WORDS  = 32,
  parameter int N      = 32768,
  parameter int LOG2_N = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                done,
  output logic [c_word_w-1:0] result [0:WORDS-1]
);

  localparam int c_fw = c_word_w * WORDS;
  localparam int c_fb = c_word_w * (WORDS - 1);
  localparam int c_cw = $clog2(c_fw) + 1;
  localparam logic [c_cw-1:0] c_log2n = c_cw'(LOG2_N);
  // x0 = 1 + 1/N; the fraction bit sits log2(N) places below the binary point
  localparam logic [c_fw-1:0] c_x0 = (c_fw'(1) << c_fb) | (c_fw'(1) << (c_fb - $clog2(N)));

  state_t          state_q;
  logic [c_fw-1:0] x_q;
  logic [c_fw-1:0] result_q;
  logic [c_cw-1:0] cnt_q;
  logic            done_q;
  logic            sq_start_q;

  logic            w_sq_done;
  logic [c_fw-1:0] w_sq_y;
  logic [c_cw-1:0] w_cnt_nxt;

  assign w_cnt_nxt = cnt_q + 1'b1;

  mp_squarer #(
    .WORDS (WORDS)
  ) squarer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (sq_start_q),
    .x_i     (x_q),
    .done_o  (w_sq_done),
    .y_o     (w_sq_y)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      sq_start_q <= 1'b0;
    end else begin
      sq_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= INIT;
        end
        INIT: begin
          x_q     <= c_x0;
          cnt_q   <= '0;
          state_q <= SQUARE;
        end
        SQUARE: begin
          sq_start_q <= 1'b1;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (w_sq_done) begin
            x_q   <= w_sq_y;
            cnt_q <= w_cnt_nxt;
            if (w_cnt_nxt < c_log2n) begin
              state_q <= SQUARE;
            end else begin
              // Raise done and the new result together so done spans the DONE cycle
              result_q <= w_sq_y;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          result_q <= x_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done = done_q;

  for (genvar k = 0; k < WORDS; k++) begin : g_result
    assign result[k] = result_q[c_word_w*k +: c_word_w];
  end

endmodule
`default_nettype wire

// File: tb/tb_e_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_e_calc : directed self-checking bench for e_calc (default and small sizes)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_e_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_b;
  logic        start_s;
  logic        done_b;
  logic        done_s;
  logic [15:0] res_b [0:31];
  logic [15:0] res_s [0:3];
  logic [15:0] ref_b [0:31];

  int n_cmp  = 0;
  int n_fail = 0;
  int done_b_cnt = 0;
  int done_s_cnt = 0;
  int cyc;
  int snap;

  always #5 clk = ~clk;

  e_calc dut_big (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_b),
    .done   (done_b),
    .result (res_b)
  );

  e_calc #(
    .WORDS  (4),
    .N      (2),
    .LOG2_N (1)
  ) dut_small (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .done   (done_s),
    .result (res_s)
  );

  always @(negedge clk) begin
    if (done_b === 1'b1) done_b_cnt++;
    if (done_s === 1'b1) done_s_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic pulse_s();
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
  endtask

  // Returns the number of negedges seen after the accepting edge
  task automatic wait_done_b(input int bound, output int c);
    c = 0;
    while (done_b !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_done_s(input int bound, output int c);
    c = 0;
    while (done_s !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    start_b = 1'b0;
    start_s = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done_big", done_b, 0);
    check("rst_done_small", done_s, 0);
    check("rst_big_w31", res_b[31], 16'h0000);
    check("rst_big_w30", res_b[30], 16'h0000);
    check("rst_big_w0", res_b[0], 16'h0000);
    for (int k = 0; k < 4; k++) check($sformatf("rst_small_w%0d", k), res_s[k], 16'h0000);
    @(posedge clk); #1 rst_n = 1'b0;

    // Small run: 1.5^2 = 2.25, then start during the DONE cycle must be ignored
    snap = done_s_cnt;
    pulse_s();
    wait_done_s(200, cyc);
    check("small_done_seen", done_s, 1);
    check("small_latency", ((cyc - 1) <= 32), 1);
    check("small_w3", res_s[3], 16'h0002);
    check("small_w2", res_s[2], 16'h4000);
    check("small_w1", res_s[1], 16'h0000);
    check("small_w0", res_s[0], 16'h0000);
    start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    @(negedge clk);
    check("small_done_one_cycle", done_s, 0);
    repeat (100) @(negedge clk);
    check("small_done_count_run1", done_s_cnt - snap, 1);
    check("small_w2_after_done_start", res_s[2], 16'h4000);

    // Small run 2: start pulse during WAIT, result held mid-run
    snap = done_s_cnt;
    pulse_s();
    repeat (6) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    @(negedge clk);
    check("small_held_w3", res_s[3], 16'h0002);
    check("small_held_w2", res_s[2], 16'h4000);
    wait_done_s(200, cyc);
    check("small2_w3", res_s[3], 16'h0002);
    check("small2_w2", res_s[2], 16'h4000);
    repeat (100) @(negedge clk);
    check("small_done_count_run2", done_s_cnt - snap, 1);

    // Default run A
    snap = done_b_cnt;
    pulse_b();
    wait_done_b(20000, cyc);
    check("bigA_done_seen", done_b, 1);
    check("bigA_latency", ((cyc - 1) <= 16384), 1);
    check("bigA_w31", res_b[31], 16'h0002);
    check("bigA_w30", res_b[30], 16'hB7DE);
    for (int k = 0; k < 32; k++) ref_b[k] = res_b[k];
    @(negedge clk);
    check("bigA_done_one_cycle", done_b, 0);

    // Back-to-back run B with a start pulse during WAIT
    pulse_b();
    repeat (3000) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk);
    check("bigB_held_w31", res_b[31], 16'h0002);
    check("bigB_held_w30", res_b[30], 16'hB7DE);
    wait_done_b(20000, cyc);
    check("bigB_done_seen", done_b, 1);
    for (int k = 0; k < 32; k++) check($sformatf("bigB_vs_A_w%0d", k), res_b[k], ref_b[k]);
    repeat (20) @(negedge clk);
    check("bigB_done_count", done_b_cnt - snap, 2);

    // Reset during the third squaring
    pulse_b();
    repeat (2500) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_done", done_b, 0);
    check("abort_w31", res_b[31], 16'h0000);
    check("abort_w30", res_b[30], 16'h0000);
    check("abort_w0", res_b[0], 16'h0000);
    snap = done_b_cnt;
    repeat (14000) @(negedge clk);
    check("abort_no_done", done_b_cnt - snap, 0);
    check("abort_w31_still_zero", res_b[31], 16'h0000);

    // Fresh run after abort
    pulse_b();
    wait_done_b(20000, cyc);
    check("bigD_done_seen", done_b, 1);
    check("bigD_latency", ((cyc - 1) <= 16384), 1);
    check("bigD_w31", res_b[31], 16'h0002);
    check("bigD_w30", res_b[30], 16'hB7DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
